max_finder: RTL and testbench

Bus-initiator block that drives the data-memory port, the reading/writing side of the memory's address/write_data/mem_read/mem_write/read_data interface. On a start pulse it scans COUNT consecutive 32-bit words from BASE_ADDR and finds the largest signed value and the index of its first occurrence. It writes the value to the memory's max word (2000) and the index to the max_index word (2004), where the memory's max/max_index taps expose them. It sits beside the pipeline as a hardware accelerator and owns the memory port only while busy.

---
 rtl/max_finder_pkg.sv | 18 +
 rtl/max_compare.sv | 12 +
 rtl/max_finder.sv | 104 ++++++++++
 tb/tb_max_finder.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/max_finder_pkg.sv
// Shared memory map and FSM state encoding for the max_finder accelerator.
// The testbench imports the same encoding to decode state.
package max_finder_pkg;

   localparam logic [31:0] WORD_BYTES        = 32'd4;
   localparam logic [31:0] MAX_ADDR          = 32'd2000;
   localparam logic [31:0] INDEX_ADDR        = MAX_ADDR + WORD_BYTES;
   localparam logic [31:0] DEFAULT_BASE_ADDR = 32'd1000;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_READ   = 3'd1,
      S_WR_MAX = 3'd2,
      S_WR_IDX = 3'd3,
      S_DONE   = 3'd4
   } state_t;

endpackage

// File: rtl/max_compare.sv
// Signed 32-bit greater-than. Update-enable is forced on the first element,
// so the first sample always seeds the running max.
module max_compare (
   input  logic [31:0] candidate,
   input  logic [31:0] current,
   input  logic        first,
   output logic        update
);

   assign update = first | ($signed(candidate) > $signed(current));

endmodule

// File: rtl/max_finder.sv
// Memory-scanning max finder: reads COUNT words from BASE_ADDR and writes the
// first-occurrence signed maximum and its index back to the memory map.
module max_finder
   import max_finder_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
   parameter int unsigned COUNT     = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic [31:0] max,
   output logic [31:0] max_index,
   output logic [31:0] address,
   output logic [31:0] write_data,
   output logic        mem_read,
   output logic        mem_write,
   input  logic [31:0] read_data
);

   localparam int unsigned IW = $clog2(COUNT + 1);

   state_t        state;
   state_t        state_next;
   logic [IW-1:0] idx;
   logic          last;
   logic          update;

   assign last = (idx == IW'(COUNT - 1));

   max_compare u_cmp (
      .candidate (read_data),
      .current   (max),
      .first     (idx == '0),
      .update    (update)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_next;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         idx       <= '0;
         max       <= '0;
         max_index <= '0;
      end else begin
         case (state)
            S_IDLE: if (start) idx <= '0;
            S_READ: begin
               idx <= idx + IW'(1);
               if (update) begin
                  max       <= read_data;
                  max_index <= 32'(idx);
               end
            end
            default: ;
         endcase
      end
   end

   // Strobes decode from state alone, so an async reset drops them before the edge.
   always_comb begin
      state_next = state;
      busy       = 1'b1;
      done       = 1'b0;
      address    = '0;
      write_data = '0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      case (state)
         S_IDLE: begin
            busy = 1'b0;
            if (start) state_next = S_READ;
         end
         S_READ: begin
            address  = BASE_ADDR + WORD_BYTES * 32'(idx);
            mem_read = 1'b1;
            if (last) state_next = S_WR_MAX;
         end
         S_WR_MAX: begin
            address    = MAX_ADDR;
            write_data = max;
            mem_write  = 1'b1;
            state_next = S_WR_IDX;
         end
         S_WR_IDX: begin
            address    = INDEX_ADDR;
            write_data = max_index;
            mem_write  = 1'b1;
            state_next = S_DONE;
         end
         S_DONE: begin
            done       = 1'b1;
            state_next = S_IDLE;
         end
         default: state_next = S_IDLE;
      endcase
   end

endmodule

// File: tb/tb_max_finder.sv
// Self-checking bench for max_finder: table vectors, random scans against a
// reference model, and hand-written reset / start-handling sequences.
module tb_max_finder;
   import max_finder_pkg::*;

   localparam logic [31:0] SENT = 32'hDEADBEEF;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // COUNT=4 instance
   logic        start, busy, done, mem_read, mem_write;
   logic [31:0] max, max_index, address, write_data, read_data;
   logic [31:0] mem [0:1023];

   // COUNT=1 instance
   logic        start1, busy1, done1, mem_read1, mem_write1;
   logic [31:0] max1, max_index1, address1, write_data1, read_data1;
   logic [31:0] mem1 [0:1023];

   max_finder #(.BASE_ADDR(32'd1000), .COUNT(4)) u_dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .max(max), .max_index(max_index), .address(address),
      .write_data(write_data), .mem_read(mem_read), .mem_write(mem_write),
      .read_data(read_data)
   );

   max_finder #(.BASE_ADDR(32'd3000), .COUNT(1)) u_dut1 (
      .clk(clk), .rst(rst), .start(start1), .busy(busy1), .done(done1),
      .max(max1), .max_index(max_index1), .address(address1),
      .write_data(write_data1), .mem_read(mem_read1), .mem_write(mem_write1),
      .read_data(read_data1)
   );

   always_comb read_data  = mem_read  ? mem[address[11:2]]   : '0;
   always_comb read_data1 = mem_read1 ? mem1[address1[11:2]] : '0;

   always @(posedge clk) begin
      if (mem_write)  mem[address[11:2]]   = write_data;
      if (mem_write1) mem1[address1[11:2]] = write_data1;
   end

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   typedef struct packed {
      logic [3:0][31:0] e;
      logic [31:0]      m;
      logic [31:0]      ix;
   } vec_t;

   function automatic vec_t mk(input logic [31:0] a, b, c, d, m, ix);
      vec_t v;
      v.e[0] = a; v.e[1] = b; v.e[2] = c; v.e[3] = d;
      v.m = m; v.ix = ix;
      return v;
   endfunction

   // Reference: first index holding the largest signed value.
   function automatic void ref_max(input logic [3:0][31:0] e,
                                   output logic [31:0] m, output logic [31:0] ix);
      int best;
      best = 0;
      for (int k = 1; k < 4; k++)
         if (int'(e[k]) > int'(e[best])) best = k;
      m  = e[best];
      ix = 32'(best);
   endfunction

   task automatic load(input logic [3:0][31:0] e);
      for (int k = 0; k < 4; k++) mem[250 + k] = e[k];
      mem[500] = SENT;
      mem[501] = SENT;
   endtask

   // Start pulse sampled at edge 0; negedge k afterwards lies in cycle k.
   task automatic run_scan(input logic [3:0][31:0] e, input logic [31:0] m,
                           input logic [31:0] ix, input string tag);
      logic [31:0] ea, ew;
      load(e);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 1; c <= 8; c++) begin
         ea = '0; ew = '0;
         if (c >= 1 && c <= 4) ea = 32'(1000 + 4 * (c - 1));
         if (c == 5) begin ea = 32'd2000; ew = m;  end
         if (c == 6) begin ea = 32'd2004; ew = ix; end
         chk($sformatf("%s c%0d mem_read", tag, c),  32'(mem_read),  32'(c >= 1 && c <= 4));
         chk($sformatf("%s c%0d mem_write", tag, c), 32'(mem_write), 32'(c == 5 || c == 6));
         chk($sformatf("%s c%0d address", tag, c),   address, ea);
         chk($sformatf("%s c%0d write_data", tag, c), write_data, ew);
         chk($sformatf("%s c%0d done", tag, c),      32'(done), 32'(c == 7));
         chk($sformatf("%s c%0d busy", tag, c),      32'(busy), 32'(c <= 7));
         @(negedge clk);
      end
      chk({tag, " mem2000"}, mem[500], m);
      chk({tag, " mem2004"}, mem[501], ix);
      chk({tag, " max"}, max, m);
      chk({tag, " max_index"}, max_index, ix);
   endtask

   vec_t tbl [5];

   initial begin
      logic [3:0][31:0] e;
      logic [31:0] m, ix;
      int ndone;

      for (int k = 0; k < 1024; k++) begin mem[k] = '0; mem1[k] = '0; end
      start = 1'b0; start1 = 1'b0;
      rst = 1'b1;
      #1;
      chk("reset busy", 32'(busy), 32'd0);
      chk("reset done", 32'(done), 32'd0);
      chk("reset max", max, 32'd0);
      chk("reset max_index", max_index, 32'd0);
      chk("reset address", address, 32'd0);
      chk("reset write_data", write_data, 32'd0);
      chk("reset mem_read", 32'(mem_read), 32'd0);
      chk("reset mem_write", 32'(mem_write), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b0;

      tbl[0] = mk(32'd3, 32'd9, 32'hFFFFFFFC, 32'd7, 32'd9, 32'd1);
      tbl[1] = mk(32'hFFFFFFFB, 32'hFFFFFFFE, 32'hFFFFFFF8, 32'hFFFFFFF8, 32'hFFFFFFFE, 32'd1);
      tbl[2] = mk(32'd6, 32'd6, 32'd2, 32'd6, 32'd6, 32'd0);
      tbl[3] = mk(32'd1, 32'd2, 32'd3, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'd3);
      tbl[4] = mk(32'h80000000, 32'd0, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'd1);
      for (int t = 0; t < 5; t++)
         run_scan(tbl[t].e, tbl[t].m, tbl[t].ix, $sformatf("vec%0d", t));

      for (int r = 0; r < 8; r++) begin
         for (int k = 0; k < 4; k++) e[k] = $urandom;
         if (r % 2 == 0) e[$urandom_range(3, 1)] = e[0];
         if (r % 3 == 0) e[3] = e[1];
         ref_max(e, m, ix);
         run_scan(e, m, ix, $sformatf("rnd%0d", r));
      end

      // Reset in READ cycle 2: nothing written, outputs clear at once.
      load(tbl[0].e);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      @(negedge clk) rst = 1'b1;
      #1;
      chk("rstrd busy", 32'(busy), 32'd0);
      chk("rstrd mem_read", 32'(mem_read), 32'd0);
      chk("rstrd address", address, 32'd0);
      chk("rstrd max", max, 32'd0);
      chk("rstrd max_index", max_index, 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (8) @(negedge clk);
      chk("rstrd busy later", 32'(busy), 32'd0);
      chk("rstrd mem2000", mem[500], SENT);
      chk("rstrd mem2004", mem[501], SENT);
      run_scan(tbl[0].e, tbl[0].m, tbl[0].ix, "after_rst");

      // Reset during WR_MAX: strobe drops before the edge, no commit.
      load(tbl[3].e);
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      repeat (4) @(negedge clk);
      chk("rstwr pre mem_write", 32'(mem_write), 32'd1);
      rst = 1'b1;
      #1;
      chk("rstwr mem_write", 32'(mem_write), 32'd0);
      chk("rstwr write_data", write_data, 32'd0);
      @(negedge clk) rst = 1'b0;
      repeat (3) @(negedge clk);
      chk("rstwr mem2000", mem[500], SENT);
      chk("rstwr mem2004", mem[501], SENT);

      // Start pulses while busy are dropped.
      load(tbl[2].e);
      ndone = 0;
      @(negedge clk) start = 1'b1;
      @(negedge clk) start = 1'b0;
      for (int c = 1; c <= 20; c++) begin
         if (done) ndone++;
         start = (c == 3 || c == 6);
         @(negedge clk);
      end
      start = 1'b0;
      chk("busystart done count", 32'(ndone), 32'd1);
      chk("busystart busy", 32'(busy), 32'd0);
      chk("busystart mem2004", mem[501], 32'd0);

      // Start held high: back-to-back scans with one IDLE cycle between.
      load(tbl[1].e);
      @(negedge clk) start = 1'b1;
      @(negedge clk);
      for (int c = 1; c <= 15; c++) begin
         chk($sformatf("held c%0d busy", c), 32'(busy), 32'(c != 8));
         chk($sformatf("held c%0d done", c), 32'(done), 32'(c == 7 || c == 15));
         @(negedge clk);
      end
      start = 1'b0;
      repeat (2) @(negedge clk);
      chk("held idle", 32'(busy), 32'd0);
      chk("held mem2000", mem[500], 32'hFFFFFFFE);

      // COUNT=1: single READ cycle, element 0 wins.
      mem1[750] = 32'h80000000;
      mem1[500] = SENT;
      mem1[501] = SENT;
      @(negedge clk) start1 = 1'b1;
      @(negedge clk) start1 = 1'b0;
      for (int c = 1; c <= 5; c++) begin
         m = (c == 1) ? 32'd3000 : (c == 2) ? 32'd2000 : (c == 3) ? 32'd2004 : 32'd0;
         chk($sformatf("c1 c%0d mem_read", c), 32'(mem_read1), 32'(c == 1));
         chk($sformatf("c1 c%0d address", c), address1, m);
         chk($sformatf("c1 c%0d done", c), 32'(done1), 32'(c == 4));
         chk($sformatf("c1 c%0d busy", c), 32'(busy1), 32'(c <= 4));
         @(negedge clk);
      end
      chk("c1 mem2000", mem1[500], 32'h80000000);
      chk("c1 mem2004", mem1[501], 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
